// File: rtl/rosc_meas_ctrl.sv
// rosc_meas_ctrl: ring-oscillator measurement controller.
// Enables the ring, lets it settle for SETTLE_CYC cycles, then counts
// synchronized rising edges of ROSC_IN over WINDOW system-clock cycles.
// The result is published on COUNT/OVF together with a one-cycle DONE.
//
// Handshake: START is a single-cycle request, accepted only when BUSY=0
// (IDLE); it is dropped, not queued, otherwise. DONE marks the cycle in
// which COUNT/OVF first show the new result; they hold until the next DONE.
//
// Build option: define ROSC_MEAS_SYNC3_EN for a 3-flop ROSC_IN synchronizer
// (one extra cycle of edge latency; state sequencing is unchanged).
module rosc_meas_ctrl #(
    parameter int WIN_W      = 16,
    parameter int CNT_W      = 20,
    parameter int SETTLE_CYC = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic             ROSC_IN,
    output logic             ROSC_EN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF,
    output logic [1:0]       state_dbg
);

`ifdef ROSC_MEAS_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif

    // One down-counter serves both the settle and the gate phase.
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int CYC_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic [WIN_W-1:0]  win_q;
    logic [CYC_W-1:0]  cyc_q;
    logic              cyc_load;
    logic [CYC_W-1:0]  cyc_load_val;
    logic [SYNC_N-1:0] sync_q;
    logic              sync_prev_q;
    logic              edge_pulse;
    logic [CNT_W-1:0]  acc_q;
    logic [CNT_W-1:0]  acc_nxt;
    logic              ovf_flag_q;
    logic              ovf_flag_nxt;
    logic              rosc_en_q;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;
    logic              start_ok;

    assign start_ok = (state_q == ST_IDLE) && START;

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic and phase-counter reload requests.
    always_comb begin
        state_nxt    = state_q;
        cyc_load     = 1'b0;
        cyc_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (WINDOW == '0) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        state_nxt    = ST_SETTLE;
                        cyc_load     = 1'b1;
                        cyc_load_val = SETTLE_LAST;
                    end
                end
            end
            ST_SETTLE: begin
                if (cyc_q == '0) begin
                    state_nxt    = ST_GATE;
                    cyc_load     = 1'b1;
                    cyc_load_val = CYC_W'(win_q) - CYC_W'(1);
                end
            end
            ST_GATE: begin
                if (cyc_q == '0) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Window capture at START acceptance.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            win_q <= '0;
        end else if (start_ok) begin
            win_q <= WINDOW;
        end
    end

    // Phase down-counter: counts the remaining cycles of SETTLE or GATE.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cyc_q <= '0;
        end else if (cyc_load) begin
            cyc_q <= cyc_load_val;
        end else if (cyc_q != '0) begin
            cyc_q <= cyc_q - CYC_W'(1);
        end
    end

    // ROSC_IN synchronizer chain plus the delayed copy for edge detection.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_N-2:0], ROSC_IN};
            sync_prev_q <= sync_q[SYNC_N-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_N-1] & ~sync_prev_q;

    // Saturating accumulator update; only GATE edges count.
    always_comb begin
        acc_nxt      = acc_q;
        ovf_flag_nxt = ovf_flag_q;
        if ((state_q == ST_GATE) && edge_pulse) begin
            if (&acc_q) begin
                ovf_flag_nxt = 1'b1;
            end else begin
                acc_nxt = acc_q + CNT_W'(1);
            end
        end
    end

    // Accumulator and overflow flag, cleared when a run is accepted.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            acc_q      <= '0;
            ovf_flag_q <= 1'b0;
        end else if (start_ok) begin
            acc_q      <= '0;
            ovf_flag_q <= 1'b0;
        end else begin
            acc_q      <= acc_nxt;
            ovf_flag_q <= ovf_flag_nxt;
        end
    end

    // Result registers load on entry to FINISH so they are valid with DONE;
    // the last GATE cycle's increment is folded in via acc_nxt.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if ((state_nxt == ST_FINISH) && (state_q != ST_FINISH)) begin
            if (state_q == ST_IDLE) begin
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                count_q <= acc_nxt;
                ovf_q   <= ovf_flag_nxt;
            end
        end
    end

    // Registered ring enable, high whenever the next state runs the ring.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rosc_en_q <= 1'b0;
        end else begin
            rosc_en_q <= (state_nxt == ST_SETTLE) || (state_nxt == ST_GATE);
        end
    end

    assign ROSC_EN   = rosc_en_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = (state_q == ST_FINISH);
    assign COUNT     = count_q;
    assign OVF       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rosc_meas_ctrl.sv
// tb_rosc_meas_ctrl: directed table-driven bench for rosc_meas_ctrl with
// CNT_W=4 so the saturation path is reachable with short windows.
module tb_rosc_meas_ctrl;

    localparam int WIN_W      = 16;
    localparam int CNT_W      = 4;
    localparam int SETTLE_CYC = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIN_W-1:0] window = '0;
    logic             rosc_in = 1'b0;
    logic             rosc_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic [1:0]       state_dbg;

    int total = 0;
    int bad   = 0;
    int half  = 5;

    logic [31:0] exp_q[$];

    typedef struct {
        int   win;
        int   half;
        int   lo;
        int   hi;
        logic ovf;
    } vec_t;

    vec_t vecs[7];

    rosc_meas_ctrl #(
        .WIN_W     (WIN_W),
        .CNT_W     (CNT_W),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .CLK      (clk),
        .RSTN     (rst_n),
        .START    (start),
        .WINDOW   (window),
        .ROSC_IN  (rosc_in),
        .ROSC_EN  (rosc_en),
        .BUSY     (busy),
        .DONE     (done),
        .COUNT    (count),
        .OVF      (ovf),
        .state_dbg(state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Ring model: square wave with period 2*half, restarting low on enable.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (rosc_en !== 1'b1) begin
                rosc_in = 1'b0;
                ph      = 0;
            end else begin
                ph++;
                if (ph >= half) begin
                    rosc_in = ~rosc_in;
                    ph      = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input logic [31:0] act, input int lo, input int hi);
        total++;
        if ($isunknown(act) || (int'(act) < lo) || (int'(act) > hi)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Wait for DONE from the current cycle (k=1 is cycle t+1), bounded.
    task automatic wait_done(output int k, output bit en_seen);
        k       = 1;
        en_seen = 1'b0;
        while ((done !== 1'b1) && (k < 400)) begin
            en_seen = en_seen | (rosc_en === 1'b1);
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no DONE after %0d cycles", k);
        end
    endtask

    // One full measurement: START, wait for DONE, check timing and handshake.
    task automatic run_meas(input int win, input int hp, output logic [CNT_W-1:0] cnt_o, output logic ovf_o);
        int k;
        bit en_seen;
        half = hp;
        exp_q.push_back((win == 0) ? 32'd1 : 32'(SETTLE_CYC + 1 + win));
        @(negedge clk);
        window = WIN_W'(win);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        if (win != 0) begin
            check("busy_t1", {31'd0, busy}, 32'd1);
            check("rosc_en_t1", {31'd0, rosc_en}, 32'd1);
        end
        wait_done(k, en_seen);
        check("done_latency", 32'(k), exp_q.pop_front());
        check("rosc_en_at_done", {31'd0, rosc_en}, 32'd0);
        if (win == 0) begin
            check("rosc_en_never", {31'd0, en_seen}, 32'd0);
        end
        cnt_o = count;
        ovf_o = ovf;
        @(negedge clk);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [CNT_W-1:0] c;
        logic             o;
        int               k;
        bit               en_seen;

        vecs[0] = '{win: 100, half: 5, lo: 9,  hi: 11, ovf: 1'b0};
        vecs[1] = '{win: 0,   half: 5, lo: 0,  hi: 0,  ovf: 1'b0};
        vecs[2] = '{win: 200, half: 4, lo: 15, hi: 15, ovf: 1'b1};
        vecs[3] = '{win: 40,  half: 4, lo: 4,  hi: 6,  ovf: 1'b0};
        vecs[4] = '{win: 60,  half: 3, lo: 9,  hi: 11, ovf: 1'b0};
        vecs[5] = '{win: 1,   half: 5, lo: 0,  hi: 1,  ovf: 1'b0};
        vecs[6] = '{win: 20,  half: 5, lo: 1,  hi: 3,  ovf: 1'b0};

        // Reset values.
        #1;
        check("rst_rosc_en", {31'd0, rosc_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven runs.
        for (int i = 0; i < 7; i++) begin
            run_meas(vecs[i].win, vecs[i].half, c, o);
            check_range($sformatf("count_v%0d", i), 32'(c), vecs[i].lo, vecs[i].hi);
            check($sformatf("ovf_v%0d", i), {31'd0, o}, {31'd0, vecs[i].ovf});
            repeat (3) @(negedge clk);
            check_range($sformatf("count_held_v%0d", i), 32'(count), vecs[i].lo, vecs[i].hi);
            check($sformatf("ovf_held_v%0d", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
        end

        // START while busy is ignored; COUNT holds mid-run.
        half = 5;
        @(negedge clk);
        window = WIN_W'(50);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        k = 1;
        while ((done !== 1'b1) && (k < 400)) begin
            start  = (k == 20);
            window = (k == 20) ? WIN_W'(7) : WIN_W'(50);
            if (k == 30) begin
                check_range("count_held_midrun", 32'(count), vecs[6].lo, vecs[6].hi);
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("busy_start_done_latency", 32'(k), 32'd59);

        // START in the cycle after DONE begins a new run.
        @(negedge clk);
        check("b2b_idle", {31'd0, busy}, 32'd0);
        window = WIN_W'(10);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_rosc_en", {31'd0, rosc_en}, 32'd1);
        wait_done(k, en_seen);
        check("b2b_done_latency", 32'(k), 32'(SETTLE_CYC + 1 + 10));
        @(negedge clk);
        check("b2b_no_second_done", {31'd0, done}, 32'd0);

        // Asynchronous reset in the middle of GATE.
        run_meas(100, 5, c, o);
        check_range("pre_reset_count", 32'(c), 9, 11);
        @(negedge clk);
        window = WIN_W'(100);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_gate_rosc_en", {31'd0, rosc_en}, 32'd1);
        check("mid_gate_state", 32'(state_dbg), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rosc_en", {31'd0, rosc_en}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_ovf", {31'd0, ovf}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("in_rst_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("post_rst_done", {31'd0, done}, 32'd0);
            check("post_rst_busy", {31'd0, busy}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
